// File: rtl/param_boot_loader.sv
// ---------------------------------------------------------------------------
// param_boot_loader
//
// Boot-time loader and dumper for a single-port CPU RAM.
//
// After reset the block owns the RAM (boot=1). It first receives
// RAM_SIZE words, MSB-first, as a byte stream on rx_data/rx_valid. It
// writes each word to RAM and then compares one trailing checksum byte
// against the mod-256 sum of all data bytes.
//   - On a mismatch it flags load_error and waits for a complete reload.
//   - On a match it releases the CPU (boot=0) and waits for scan_memory.
//
// A scan request reads every word back. Each word goes out MSB-first on
// tx_data/tx_valid/tx_ready, followed by TX_GAP_CYCLES idle cycles. The
// mod-256 sum of the transmitted bytes is sent last. The block then
// parks in DONE until the next reset.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   ce           clock enable; nothing advances while ce=0
//   rx_data      received byte
//   rx_valid     rx_data valid (one-cycle pulse)
//   tx_data      byte to transmit
//   tx_valid     tx_data valid
//   tx_ready     transmitter accepts the presented byte
//   scan_memory  request a memory dump
//   boot         1 = loader owns the RAM, CPU held
//   load_error   sticky checksum-mismatch flag of the last load
//   done         dump finished
//   ram_out      RAM read data, valid one cycle after a read strobe
//   ram_rw       1 = write, 0 = read
//   ram_enable   RAM access strobe
//   ram_adr      RAM word address
//   ram_in       RAM write data
// ---------------------------------------------------------------------------
module param_boot_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int RAM_ADR_WIDTH = 6,
  parameter int RAM_SIZE      = 64,
  parameter int TX_GAP_CYCLES = 18000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic                     scan_memory,
  output logic                     boot,
  output logic                     load_error,
  output logic                     done,
  input  logic [DATA_WIDTH-1:0]    ram_out,
  output logic                     ram_rw,
  output logic                     ram_enable,
  output logic [RAM_ADR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0]    ram_in
);

  localparam int BYTES = DATA_WIDTH / 8;

  // The gap counter only has to reach TX_GAP_CYCLES-1. Keep it at
  // least one bit wide so that a zero gap still elaborates cleanly.
  localparam int GAP_W = (TX_GAP_CYCLES < 2) ? 1 : $clog2(TX_GAP_CYCLES);

  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((TX_GAP_CYCLES > 0) ? TX_GAP_CYCLES - 1 : 0);
  localparam logic [RAM_ADR_WIDTH-1:0] ADR_LAST = RAM_ADR_WIDTH'(RAM_SIZE - 1);
  localparam logic [1:0]               IDX_LAST = 2'(BYTES - 1);

  typedef enum logic [3:0] {
    RX_WAIT   = 4'd0,
    RX_WRITE  = 4'd1,
    RX_CHECK  = 4'd2,
    WAIT_SCAN = 4'd3,
    TX_READ   = 4'd4,
    TX_LOAD   = 4'd5,
    TX_SEND   = 4'd6,
    TX_GAP    = 4'd7,
    TX_SUM    = 4'd8,
    DONE      = 4'd9
  } state_e;

  state_e                   state_q,      state_d;
  logic [RAM_ADR_WIDTH-1:0] adr_q,        adr_d;
  logic [1:0]               idx_q,        idx_d;
  logic [7:0]               rx_sum_q,     rx_sum_d;
  logic [7:0]               tx_sum_q,     tx_sum_d;
  logic [GAP_W-1:0]         gap_q,        gap_d;
  logic [DATA_WIDTH-1:0]    word_q,       word_d;
  logic [DATA_WIDTH-1:0]    shift_q,      shift_d;
  logic                     load_error_q, load_error_d;

  // Set in the transmit path when a word and its gap are both finished.
  // The address advance is then shared by TX_SEND and TX_GAP.
  logic                     word_done;

  logic [7:0]               tx_byte;
  assign tx_byte = shift_q[DATA_WIDTH-1 -: 8];

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    adr_d        = adr_q;
    idx_d        = idx_q;
    rx_sum_d     = rx_sum_q;
    tx_sum_d     = tx_sum_q;
    gap_d        = gap_q;
    word_d       = word_q;
    shift_d      = shift_q;
    load_error_d = load_error_q;
    word_done    = 1'b0;

    if (ce) begin
      unique case (state_q)
        RX_WAIT: begin
          if (rx_valid) begin
            // Shifting left leaves the first byte of the word in the top
            // lane once all BYTES bytes have arrived.
            word_d   = (word_q << 8) | DATA_WIDTH'(rx_data);
            rx_sum_d = rx_sum_q + rx_data;
            if (idx_q == IDX_LAST) begin
              idx_d   = 2'd0;
              state_d = RX_WRITE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end

        RX_WRITE: begin
          if (adr_q == ADR_LAST) begin
            adr_d   = '0;
            state_d = RX_CHECK;
          end else begin
            adr_d   = adr_q + 1'b1;
            state_d = RX_WAIT;
          end
        end

        RX_CHECK: begin
          if (rx_valid) begin
            if (rx_data == rx_sum_q) begin
              load_error_d = 1'b0;
              state_d      = WAIT_SCAN;
            end else begin
              // Restart a complete load from word 0 with a fresh sum.
              load_error_d = 1'b1;
              adr_d        = '0;
              rx_sum_d     = 8'h00;
              idx_d        = 2'd0;
              state_d      = RX_WAIT;
            end
          end
        end

        WAIT_SCAN: begin
          if (scan_memory) begin
            adr_d    = '0;
            tx_sum_d = 8'h00;
            idx_d    = 2'd0;
            state_d  = TX_READ;
          end
        end

        TX_READ: begin
          state_d = TX_LOAD;
        end

        TX_LOAD: begin
          // ram_out carries the word read by the strobe in TX_READ.
          shift_d = ram_out;
          idx_d   = 2'd0;
          state_d = TX_SEND;
        end

        TX_SEND: begin
          if (tx_ready) begin
            tx_sum_d = tx_sum_q + tx_byte;
            if (idx_q == IDX_LAST) begin
              idx_d = 2'd0;
              if (TX_GAP_CYCLES == 0) begin
                word_done = 1'b1;
              end else begin
                gap_d   = '0;
                state_d = TX_GAP;
              end
            end else begin
              shift_d = shift_q << 8;
              idx_d   = idx_q + 2'd1;
            end
          end
        end

        TX_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d     = '0;
            word_done = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end

        TX_SUM: begin
          if (tx_ready) begin
            state_d = DONE;
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = RX_WAIT;
        end
      endcase

      if (word_done) begin
        if (adr_q == ADR_LAST) begin
          adr_d   = '0;
          state_d = TX_SUM;
        end else begin
          adr_d   = adr_q + 1'b1;
          state_d = TX_READ;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the word and shift registers are plain flops, not memories, so
  // they get a reset like all other state. A partial word therefore never
  // survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_WAIT;
      adr_q        <= '0;
      idx_q        <= 2'd0;
      rx_sum_q     <= 8'h00;
      tx_sum_q     <= 8'h00;
      gap_q        <= '0;
      word_q       <= '0;
      shift_q      <= '0;
      load_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its new value
      // from the same pre-edge snapshot, independent of statement order.
      state_q      <= state_d;
      adr_q        <= adr_d;
      idx_q        <= idx_d;
      rx_sum_q     <= rx_sum_d;
      tx_sum_q     <= tx_sum_d;
      gap_q        <= gap_d;
      word_q       <= word_d;
      shift_q      <= shift_d;
      load_error_q <= load_error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: registers, or decodes of the registered state only
  // -------------------------------------------------------------------------
  assign boot       = (state_q != WAIT_SCAN) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign load_error = load_error_q;
  assign ram_enable = (state_q == RX_WRITE) || (state_q == TX_READ);
  assign ram_rw     = (state_q == RX_WRITE);
  assign ram_adr    = adr_q;
  assign ram_in     = word_q;
  assign tx_valid   = (state_q == TX_SEND) || (state_q == TX_SUM);
  assign tx_data    = (state_q == TX_SUM)  ? tx_sum_q :
                      (state_q == TX_SEND) ? tx_byte  : 8'h00;

endmodule

// File: tb/tb_param_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_param_boot_loader
//
// Directed bench for param_boot_loader with DATA_WIDTH=16, RAM_SIZE=4 and
// TX_GAP_CYCLES=3. A small behavioural RAM sits on the DUT's RAM port.
// Inputs are driven on the falling edge and outputs are sampled there,
// away from the active rising edge.
//
// Reference stream: 12 34 56 78 9A BC DE F0. The sum of these bytes is
// 1080, and 1080 mod 256 = 0x38, so 0x38 is the checksum that is
// accepted. It is also the final byte of the dump.
// ---------------------------------------------------------------------------
module tb_param_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        scan_memory;
  logic        boot;
  logic        load_error;
  logic        done;
  logic [15:0] ram_out;
  logic        ram_rw;
  logic        ram_enable;
  logic [1:0]  ram_adr;
  logic [15:0] ram_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [4];
  logic        mem_clr = 1'b0;

  logic [7:0]  load_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                  8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [15:0] exp_words  [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [7:0]  exp_tx     [9] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                  8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
  // Idle (tx_valid=0) cycles before each byte.
  //   Before byte 0: TX_READ and TX_LOAD.
  //   Before bytes 2, 4 and 6: a 3-cycle gap, then TX_READ and TX_LOAD.
  //   Before the checksum: only the 3-cycle gap.
  int          exp_gap    [9] = '{2, 0, 5, 0, 5, 0, 5, 0, 3};
  logic [7:0]  got_tx     [9];
  int          got_gap    [9];

  param_boot_loader #(
    .DATA_WIDTH   (16),
    .RAM_ADR_WIDTH(2),
    .RAM_SIZE     (4),
    .TX_GAP_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .scan_memory(scan_memory),
    .boot       (boot),
    .load_error (load_error),
    .done       (done),
    .ram_out    (ram_out),
    .ram_rw     (ram_rw),
    .ram_enable (ram_enable),
    .ram_adr    (ram_adr),
    .ram_in     (ram_in)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'hDEAD;
    end else if (ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_in;
      else        ram_out      <= mem[ram_adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rx pulse, then one idle cycle so that RX_WRITE never swallows a byte.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // The real byte is sent on a ce=1 cycle. Junk pulses are sent on the
  // surrounding ce=0 cycles and must be ignored.
  task automatic send_byte_ce(input logic [7:0] b);
    @(negedge clk); ce = 1'b1; rx_valid = 1'b1; rx_data = b;
    @(negedge clk); ce = 1'b0; rx_valid = 1'b1; rx_data = 8'hA5;
    @(negedge clk); ce = 1'b1; rx_valid = 1'b0;
    @(negedge clk); ce = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
  endtask

  task automatic clear_mem();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s_word%0d", tag, i), mem[i], exp_words[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_boot"},       boot,       1);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_done"},       done,       0);
    check({tag, "_tx_valid"},   tx_valid,   0);
    check({tag, "_ram_enable"}, ram_enable, 0);
    check({tag, "_ram_rw"},     ram_rw,     0);
    check({tag, "_ram_adr"},    ram_adr,    0);
    check({tag, "_ram_in"},     ram_in,     0);
    check({tag, "_tx_data"},    tx_data,    0);
  endtask

  initial begin
    int n_bytes;
    int idle;
    int stable;
    bit stalled;

    rst = 1'b0; ce = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    tx_ready = 1'b0; scan_memory = 1'b0;

    // ---- Reset state ----
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk); rst = 1'b1;
    clear_mem();

    // ---- Load with a wrong checksum ----
    for (int i = 0; i < 8; i++) send_byte(load_bytes[i]);
    send_byte(8'h00);
    check("bad_load_error", load_error, 1);
    check("bad_load_boot",  boot,       1);
    check("bad_load_adr",   ram_adr,    0);
    check_mem("bad_load");

    // ---- Reload with ce toggling and junk pulses on the ce=0 cycles ----
    clear_mem();
    for (int i = 0; i < 8; i++) send_byte_ce(load_bytes[i]);
    send_byte_ce(8'h38);
    @(negedge clk); ce = 1'b1; rx_valid = 1'b0;
    check("ce_load_error_cleared", load_error, 0);
    check("ce_load_boot",          boot,       0);
    check("wait_scan_done",        done,       0);
    check_mem("ce_load");

    // ---- A scan request while ce=0 must be ignored ----
    @(negedge clk); ce = 1'b0; scan_memory = 1'b1;
    @(negedge clk); ce = 1'b1; scan_memory = 1'b0;
    check("scan_ignored_boot",     boot,     0);
    check("scan_ignored_tx_valid", tx_valid, 0);

    // ---- Dump, with a 10-cycle tx_ready stall on the third byte ----
    tx_ready = 1'b1;
    @(negedge clk); scan_memory = 1'b1;
    @(negedge clk); scan_memory = 1'b0;
    n_bytes = 0; idle = 0; stable = 0; stalled = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (tx_valid) begin
        if (n_bytes == 2 && !stalled) begin
          stalled  = 1'b1;
          tx_ready = 1'b0;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_data === exp_tx[2]) stable++;
          end
          tx_ready = 1'b1;
        end
        if (n_bytes < 9) begin
          got_tx[n_bytes]  = tx_data;
          got_gap[n_bytes] = idle;
        end
        n_bytes++;
        idle = 0;
      end else begin
        idle++;
      end
      @(negedge clk);
    end
    check("dump_done_within_budget", done,    1);
    check("dump_byte_count",         n_bytes, 9);
    check("stall_stable",            stable,  10);
    for (int i = 0; i < 9 && i < n_bytes; i++) begin
      check($sformatf("tx_byte%0d", i), got_tx[i],  exp_tx[i]);
      check($sformatf("tx_gap%0d", i),  got_gap[i], exp_gap[i]);
    end
    check("done_boot",       boot,       0);
    check("done_tx_valid",   tx_valid,   0);
    check("done_ram_enable", ram_enable, 0);
    repeat (3) @(negedge clk);
    check("done_terminal", done, 1);

    // ---- Reset part-way through a load ----
    tx_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("mid_load_adr", ram_adr, 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk); rst = 1'b1;
    clear_mem();
    for (int i = 0; i < 8; i++) send_byte(load_bytes[i]);
    send_byte(8'h38);
    check("reload_load_error", load_error, 0);
    check("reload_boot",       boot,       0);
    check_mem("reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
